inst_fetch_buf: RTL
===================

// Module: inst_fetch_buf
// PURPOSE
//  Parametrised successor of the combinational fetch stage: owns the PC, issues
//  one-outstanding read requests to instruction RAM and buffers fetched
//  (pc, inst) pairs in a DEPTH-entry FIFO. Sits between the PC/branch logic and
//  if_id, and decouples memory latency from decode stalls via valid/ready.
//  Handles redirects (jump/trap) by flushing the FIFO and discarding any
//  stale in-flight response.
// PARAMETERS
//  ADDR_W   64            fetch address width
//  INST_W   32            instruction width; memory beat is 64 bits
//  DEPTH    4             FIFO entries, power of two, >=2
//  RESET_PC 64'h8000_0000 first fetch address after reset
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high
//  jump_flag_i  in   1       redirect request this cycle
//  jump_addr_i  in   ADDR_W  redirect target; bits [1:0] treated as 0
//  ren_o        out  1       read request valid
//  raddr_o      out  ADDR_W  read address, 8-byte aligned (pc & ~7)
//  ram_ready_i  in   1       memory accepts request when ren_o && ram_ready_i
//  ram_rvalid_i in   1       response valid, in order, >=1 cycle after accept
//  ram_inst_i   in   64      response data beat
//  inst_valid_o out  1       FIFO head valid
//  inst_ready_i in   1       if_id consumes head when valid && ready
//  inst_addr_o  out  ADDR_W  PC of head entry
//  inst_o       out  INST_W  head instruction
// BEHAVIOUR
//  - Reset: state=REQ, fetch_pc=RESET_PC, FIFO empty; ren_o=0, raddr_o=0,
//    inst_valid_o=0, inst_addr_o=0, inst_o=0 during and 1 cycle after reset.
//  - Clock/reset: single clk; rst is synchronous and active-high.
//  - FSM states: REQ, WAIT, DROP.
//    REQ: ren_o=1 iff count<DEPTH. On accept, latch req_pc=fetch_pc,
//      fetch_pc+=4, go to WAIT.
//    WAIT: ren_o=0. On ram_rvalid_i, push {req_pc, word}, go to REQ.
//    DROP: ren_o=0. On ram_rvalid_i, discard, go to REQ.
//  - Word select: inst = req_pc[2] ? ram_inst_i[63:32] : ram_inst_i[31:0].
//  - The space check counts the in-flight request, so a push never overflows.
//    Push and pop in the same cycle are legal at any fill level, including full.
//  - Redirect (jump_flag_i=1), highest priority:
//    * FIFO cleared; the same-cycle pop is ignored.
//    * fetch_pc <= {jump_addr_i[ADDR_W-1:2], 2'b00}.
//    * REQ: no request is accepted this cycle (ren_o may be 1 but is
//      ignored); next state REQ.
//    * WAIT: with ram_rvalid_i the response is dropped and next state is REQ;
//      without it, next state is DROP.
//    * DROP: stays DROP; the new target is kept.
//  - Outputs: inst_valid_o = count!=0; inst_addr_o/inst_o come from the head.
//    Head data is stable while valid && !ready.
//  - Latency: response at cycle N -> inst_valid_o=1 at N+1. Redirect at N ->
//    first request for the target at N+1.
//  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - Reset mid-WAIT: the later response is ignored (state REQ, pending lost);
//    the memory side must also reset.
// CONFIGURATION
//  IFU_TRACE_EN defined: on every push, $display
//    "[inst_fetch_buf] pc_addr: %x inst: %x" (low 32 bits of pc);
//    on every redirect, $display "[inst_fetch_buf] redirect: %x".
//  IFU_TRACE_EN undefined: no simulation output; RTL otherwise identical.
// TESTING
//  1 Reset, ram_ready=1, 1-cycle rvalid, inst_ready=1 -> pcs 8000_0000,
//    8000_0004, 8000_0008 in order; inst picks low/high half per pc[2].
//  2 inst_ready=0 with DEPTH=4 -> exactly 4 pushes, then ren_o=0.
//    Raise ready -> FIFO drains in order; no loss or duplicate.
//  3 Jump to 8000_0100 while in WAIT; rvalid 3 cycles later -> stale word
//    dropped; next inst_addr_o=8000_0100.
//  4 Jump in the same cycle as rvalid and pop -> FIFO empty next cycle,
//    ren_o=1 with raddr_o=8000_0100.
//  5 jump_addr_i=8000_0206 -> fetch at 8000_0204, high half selected.
//  6 Assert rst during WAIT, rvalid arrives after reset -> ignored;
//    first output pc=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - PC owner with single-outstanding instruction fetch and (pc, inst) FIFO
// Define IFU_TRACE_EN to print push and redirect trace lines in simulation.
module inst_fetch_buf #(
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   output logic              ren_o,
   output logic [ADDR_W-1:0] raddr_o,
   input  logic              ram_ready_i,
   input  logic              ram_rvalid_i,
   input  logic [63:0]       ram_inst_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic [INST_W-1:0] inst_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              post_rst;
   logic              out_gate;
   logic              ren;
   logic              accept;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_pc;
   logic [ADDR_W-1:0] jump_tgt;
   logic [31:0]       sel_word;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic              unused_jump_lsbs;

   // Outputs are held quiet while in reset and for the first cycle after it.
   assign out_gate         = rst || post_rst;
   assign jump_tgt         = {jump_addr_i[ADDR_W-1:2], 2'b00};
   assign sel_word         = req_pc[2] ? ram_inst_i[63:32] : ram_inst_i[31:0];
   assign unused_jump_lsbs = ^jump_addr_i[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         post_rst <= 1'b1;
      end else begin
         post_rst <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_REQ;
      end else begin
         state <= state_nxt;
      end
   end

   // Only one request is ever in flight, so requesting while count<DEPTH
   // guarantees room for its response.
   always_comb begin
      state_nxt = state;
      ren       = 1'b0;
      accept    = 1'b0;
      push      = 1'b0;
      case (state)
         ST_REQ: begin
            ren = !out_gate && (count < FULL_CNT);
            if (!jump_flag_i && ren && ram_ready_i) begin
               accept    = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ram_rvalid_i) begin
               push      = !jump_flag_i;
               state_nxt = ST_REQ;
            end else if (jump_flag_i) begin
               state_nxt = ST_DROP;
            end
         end
         ST_DROP: begin
            if (ram_rvalid_i) begin
               state_nxt = ST_REQ;
            end
         end
         default: begin
            state_nxt = ST_REQ;
         end
      endcase
   end

   assign pop = inst_valid_o && inst_ready_i && !jump_flag_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (jump_flag_i) begin
         fetch_pc <= jump_tgt;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(4);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= req_pc;
         inst_mem[wr_ptr] <= INST_W'(sel_word);
      end
   end

   assign ren_o        = ren;
   assign raddr_o      = out_gate ? '0 : {fetch_pc[ADDR_W-1:3], 3'b000};
   assign inst_valid_o = !out_gate && (count != '0);
   assign inst_addr_o  = inst_valid_o ? pc_mem[rd_ptr] : '0;
   assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : '0;

`ifdef IFU_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (push) begin
            $display("[inst_fetch_buf] pc_addr: %x inst: %x", req_pc[31:0], INST_W'(sel_word));
         end
         if (jump_flag_i) begin
            $display("[inst_fetch_buf] redirect: %x", jump_tgt);
         end
      end
   end
`else
`endif

endmodule
